seg_scan_ctrl: RTL and testbench

- Scan controller for the 8-digit seven-segment display.
- Holds an 8-entry character buffer that the Morse decoder fills by shift-in: the newest character appears on the rightmost digit and older ones scroll left.
- Time-multiplexes the anodes with a dead-time blank phase between digits to suppress ghosting.
- Drives active-low segments and anodes straight to the board pins.

---
 rtl/seg_scan_ctrl.sv | 117 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller with a shift-in character buffer.
// Each digit slot starts with BLANK_CYCLES of dead time; writes are only taken then.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 10000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic       clk_10Mhz,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [5:0] char_code,
  output logic       char_ready,
  input  logic       clear,
  input  logic       disp_en,
  output logic [7:0] an_sel,
  output logic [6:0] seg,
  output logic [2:0] cur_digit
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [TW-1:0] T_LAST  = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] T_BLAST = TW'(BLANK_CYCLES - 1);
  localparam logic [5:0]    BLANK_CODE = 6'd36;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [5:0]    char_buf [8];
  logic          clear_pend;
  logic          clear_now;

  function automatic logic [6:0] glyph(input logic [5:0] c);
    case (c)
      6'd0:  return 7'b1000000;
      6'd1:  return 7'b1111001;
      6'd2:  return 7'b0100100;
      6'd3:  return 7'b0110000;
      6'd4:  return 7'b0011001;
      6'd5:  return 7'b0010010;
      6'd6:  return 7'b0000010;
      6'd7:  return 7'b1111000;
      6'd8:  return 7'b0000000;
      6'd9:  return 7'b0010000;
      6'd10: return 7'b0001000; // A
      6'd11: return 7'b0000011; // b
      6'd12: return 7'b1000110; // C
      6'd13: return 7'b0100001; // d
      6'd14: return 7'b0000110; // E
      6'd15: return 7'b0001110; // F
      6'd16: return 7'b1000010; // G
      6'd17: return 7'b0001001; // H
      6'd18: return 7'b1001111; // I
      6'd19: return 7'b1100001; // J
      6'd21: return 7'b1000111; // L
      6'd23: return 7'b0101011; // n
      6'd24: return 7'b1000000; // O
      6'd25: return 7'b0001100; // P
      6'd26: return 7'b0011000; // q
      6'd27: return 7'b0101111; // r
      6'd28: return 7'b0010010; // S
      6'd29: return 7'b0000111; // t
      6'd30: return 7'b1000001; // U
      6'd34: return 7'b0010001; // y
      6'd35: return 7'b0100100; // Z
      6'd20, 6'd22, 6'd31, 6'd32, 6'd33: return 7'b0110110;
      default: return 7'b1111111;
    endcase
  endfunction

  assign char_ready = (state == ST_BLANK) && !reset;
  assign clear_now  = (state == ST_BLANK) && (clear || clear_pend);

  always_ff @(posedge clk_10Mhz) begin
    if (reset) begin
      state      <= ST_BLANK;
      timer      <= '0;
      cur_digit  <= 3'd0;
      an_sel     <= 8'hFF;
      seg        <= 7'h7F;
      clear_pend <= 1'b0;
      for (int i = 0; i < 8; i++) char_buf[i] <= BLANK_CODE;
    end else begin
      if (timer == T_LAST) begin
        timer     <= '0;
        cur_digit <= cur_digit + 3'd1;
        state     <= ST_BLANK;
      end else begin
        timer <= timer + 1'b1;
        if (timer == T_BLAST) state <= ST_SHOW;
      end

      // Outputs reflect the pre-edge slot, so anode moves lag the digit change by a cycle.
      if (state == ST_SHOW && disp_en) begin
        an_sel <= ~(8'b1 << cur_digit);
        seg    <= glyph(char_buf[cur_digit]);
      end else begin
        an_sel <= 8'hFF;
        seg    <= 7'h7F;
      end

      if (state == ST_BLANK) begin
        clear_pend <= 1'b0;
        if (clear_now) begin
          for (int i = 0; i < 8; i++) char_buf[i] <= BLANK_CODE;
        end
        if (char_valid) begin
          char_buf[0] <= char_code;
          for (int i = 1; i < 8; i++)
            char_buf[i] <= clear_now ? BLANK_CODE : char_buf[i-1];
        end
      end else begin
        clear_pend <= clear_pend | clear;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle-count reference model plus glyph table and scenario checks.
module tb_seg_scan_ctrl;

  localparam int RD = 20;
  localparam int BC = 4;

  logic       clk_10Mhz = 1'b0;
  logic       reset = 1'b1;
  logic       char_valid = 1'b0;
  logic [5:0] char_code = 6'd0;
  logic       clear = 1'b0;
  logic       disp_en = 1'b1;
  logic       char_ready;
  logic [7:0] an_sel;
  logic [6:0] seg;
  logic [2:0] cur_digit;

  seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk_10Mhz (clk_10Mhz),
    .reset     (reset),
    .char_valid(char_valid),
    .char_code (char_code),
    .char_ready(char_ready),
    .clear     (clear),
    .disp_en   (disp_en),
    .an_sel    (an_sel),
    .seg       (seg),
    .cur_digit (cur_digit)
  );

  always #50 clk_10Mhz = ~clk_10Mhz;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: time is a plain cycle count since reset, buffer is an int array.
  int         mcount;
  int         mbuf [8];
  bit         mpend;
  bit         last_acc;
  logic [7:0] e_an;
  logic [6:0] e_seg;

  typedef struct {
    logic [5:0] code;
    logic [6:0] seg;
  } gvec_t;
  gvec_t gtab [13];

  // Active-high gfedcba patterns, inverted on return.
  function automatic logic [6:0] glyph_ref(input int c);
    logic [7:0] hi;
    case (c)
      0: hi = 8'h3F;  1: hi = 8'h06;  2: hi = 8'h5B;  3: hi = 8'h4F;
      4: hi = 8'h66;  5: hi = 8'h6D;  6: hi = 8'h7D;  7: hi = 8'h07;
      8: hi = 8'h7F;  9: hi = 8'h6F;  10: hi = 8'h77; 11: hi = 8'h7C;
      12: hi = 8'h39; 13: hi = 8'h5E; 14: hi = 8'h79; 15: hi = 8'h71;
      16: hi = 8'h3D; 17: hi = 8'h76; 18: hi = 8'h30; 19: hi = 8'h1E;
      21: hi = 8'h38; 23: hi = 8'h54; 24: hi = 8'h3F; 25: hi = 8'h73;
      26: hi = 8'h67; 27: hi = 8'h50; 28: hi = 8'h6D; 29: hi = 8'h78;
      30: hi = 8'h3E; 34: hi = 8'h6E; 35: hi = 8'h5B;
      20, 22, 31, 32, 33: hi = 8'h49;
      default: hi = 8'h00;
    endcase
    return ~hi[6:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mcount = 0;
    for (int i = 0; i < 8; i++) mbuf[i] = 36;
    mpend = 0;
    last_acc = 0;
    e_an = 8'hFF;
    e_seg = 7'h7F;
  endtask

  // One clock: predict from pre-edge inputs, then compare registered outputs after the edge.
  task automatic step();
    int t, d;
    bit blank, lit, clr;
    #2;
    t = mcount % RD;
    d = (mcount / RD) % 8;
    blank = (t < BC);
    if (reset) begin
      check("ready_in_reset", char_ready, 0);
      model_reset();
    end else begin
      check("char_ready", char_ready, blank);
      lit = !blank && disp_en;
      e_an = lit ? ~(8'd1 << d) : 8'hFF;
      e_seg = lit ? glyph_ref(mbuf[d]) : 7'h7F;
      clr = blank && (clear || mpend);
      mpend = blank ? 1'b0 : (mpend || clear);
      if (clr) for (int i = 0; i < 8; i++) mbuf[i] = 36;
      last_acc = char_valid && blank;
      if (last_acc) begin
        for (int i = 7; i > 0; i--) mbuf[i] = mbuf[i-1];
        mbuf[0] = char_code;
      end
      mcount++;
    end
    @(posedge clk_10Mhz);
    #1;
    check("an_sel", an_sel, e_an);
    check("seg", seg, e_seg);
    check("cur_digit", cur_digit, (mcount / RD) % 8);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int tmod);
    for (int i = 0; i < RD && (mcount % RD) != tmod; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic write_char(input int code);
    bit done = 0;
    char_valid = 1'b1;
    char_code = 6'(code);
    for (int i = 0; i < 3 * RD && !done; i++) begin
      step();
      done = last_acc;
    end
    char_valid = 1'b0;
    check("write_timeout", done, 1);
  endtask

  task automatic wait_lit(input int d, input logic [6:0] exp, input string name);
    bit found = 0;
    logic [7:0] m;
    m = 8'd1 << d;
    m = ~m;
    for (int i = 0; i < 10 * RD && !found; i++) begin
      step();
      found = (an_sel === m);
    end
    check({name, "_lit_timeout"}, found, 1);
    if (found) check(name, seg, exp);
  endtask

  initial begin
    int d0;
    bit lit_ok;
    gtab[0]  = '{6'd0,  7'b1000000};
    gtab[1]  = '{6'd1,  7'b1111001};
    gtab[2]  = '{6'd8,  7'b0000000};
    gtab[3]  = '{6'd10, 7'b0001000};
    gtab[4]  = '{6'd14, 7'b0000110};
    gtab[5]  = '{6'd17, 7'b0001001};
    gtab[6]  = '{6'd36, 7'b1111111};
    gtab[7]  = '{6'd63, 7'b1111111};
    gtab[8]  = '{6'd20, 7'b0110110};
    gtab[9]  = '{6'd22, 7'b0110110};
    gtab[10] = '{6'd31, 7'b0110110};
    gtab[11] = '{6'd32, 7'b0110110};
    gtab[12] = '{6'd33, 7'b0110110};

    model_reset();
    do_reset();
    check("reset_an", an_sel, 8'hFF);
    check("reset_seg", seg, 7'h7F);
    check("reset_digit", cur_digit, 0);

    // Idle frame plus wrap back to digit 0.
    run(8 * RD + 2);

    foreach (gtab[k]) begin
      do_reset();
      write_char(gtab[k].code);
      wait_lit(0, gtab[k].seg, $sformatf("glyph_%0d", gtab[k].code));
    end

    do_reset();
    write_char(1);
    write_char(14);
    wait_lit(0, 7'b0000110, "two_writes_d0");
    wait_lit(1, 7'b1111001, "two_writes_d1");

    // Request during SHOW must wait for the next slot's first BLANK cycle.
    run_until(5);
    write_char(0);
    check("accept_slot_start", (mcount - 1) % RD, 0);

    do_reset();
    for (int c = 0; c <= 8; c++) write_char(c);
    wait_lit(7, 7'b1111001, "nine_d7");
    wait_lit(0, 7'b0000000, "nine_d0");

    run_until(6);
    run(1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    run_until(0);
    write_char(10);
    check("clear_write_first_cycle", (mcount - 1) % RD, 0);
    wait_lit(0, 7'b0001000, "clear_d0");
    wait_lit(1, 7'b1111111, "clear_d1");
    wait_lit(7, 7'b1111111, "clear_d7");

    write_char(5);
    run_until(10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midslot_reset_an", an_sel, 8'hFF);
    check("midslot_reset_digit", cur_digit, 0);
    wait_lit(0, 7'b1111111, "midslot_reset_d0");
    wait_lit(1, 7'b1111111, "midslot_reset_d1");

    run_until(0);
    d0 = cur_digit;
    disp_en = 1'b0;
    run(8 * RD);
    check("dark_frame_digit", cur_digit, d0);
    run(RD);
    check("dark_digit_advance", cur_digit, (d0 + 1) % 8);
    run_until(8);
    disp_en = 1'b1;
    step();
    lit_ok = (an_sel != 8'hFF);
    check("reenable_lit", lit_ok, 1);

    // Random traffic; the producer holds each character until it is taken.
    for (int n = 0; n < 4000; n++) begin
      if (!char_valid && $urandom_range(3) == 0) begin
        char_valid = 1'b1;
        char_code = 6'($urandom_range(63));
      end
      clear = ($urandom_range(40) == 0);
      if ($urandom_range(150) == 0) disp_en = ~disp_en;
      reset = ($urandom_range(900) == 0);
      step();
      if (last_acc) char_valid = 1'b0;
    end
    reset = 1'b0;
    clear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
